line_buffer_ram: RTL
====================

# line_buffer_ram

Parametrised line-oriented frame store and the successor to the fixed 16-bit × 256-word × 32-line RAM. Accepts a stream of DATA_W-bit words, groups them into lines of WORDS_PER_LINE words and commits complete lines to a LINES-deep store. In read mode it plays the committed lines back word by word, in order, with valid/ready flow control. It sits between the capture front end and the downstream word consumer.

## Interface
- DATA_W, 16, word width in bits.
- WORDS_PER_LINE, 256, words per line (power of two, ≥2).
- LINES, 32, line capacity (power of two, ≥2).
- Derived: WA = clog2(WORDS_PER_LINE), LA = clog2(LINES).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- write1_read0  in  1  mode select: 1 = write, 0 = read.
- in_valid  in  1  data_in is valid this cycle.
- data_in  in  DATA_W  write word.
- in_ready  out  1  block accepts a word; reset 0.
- out_ready  in  1  consumer accepts data_out.
- out_valid  out  1  data_out holds a valid word; reset 0.
- data_out  out  DATA_W  read word; reset 0.
- line_count  out  LA+1  committed lines, 0..LINES; reset 0.
- full  out  1  line_count == LINES; reset 0.
- empty  out  1  read mode with all committed words delivered, or line_count == 0; reset 1.
- overflow  out  1  sticky; a word was offered while full; reset 0.
- parity_err  out  1  only with LINE_RAM_PARITY_EN; reset 0.

## Operation
- Mode is sampled each rising edge. A sampled 0→1 change is a frame start: line_count, wr_line, word_cnt and overflow clear. A sampled 1→0 change is read start: rd_line and rd_word clear and any partial line is discarded (word_cnt clears, line_count unchanged).
- Write mode: in_ready = !full. A word is accepted when in_valid && in_ready and is stored at {wr_line, word_cnt}, then word_cnt increments. When the word is accepted at word_cnt == WORDS_PER_LINE-1, word_cnt wraps to 0, wr_line increments and line_count increments on the same edge.
- A line is visible to reads only after it is committed. A partially filled line is never read.
- Full: in_valid with full set sets overflow and drops the word. No state other than overflow changes.
- Read mode: in_ready = 0. Words are produced in order: rd_word 0..WORDS_PER_LINE-1 within rd_line, for rd_line 0..line_count-1. Reading does not consume lines; a new read start replays the frame from line 0.
- Output register: data_out and out_valid load the next word when !out_valid || out_ready. While out_valid && !out_ready, data_out holds.
- After the last word of line line_count-1 is accepted, out_valid drops and empty asserts. In read mode with line_count == 0, out_valid stays 0 and empty = 1.
- Asserting reset at any point, including mid-line or mid-read, returns every output to its reset value within the same cycle (asynchronous). Stored memory contents are not cleared.

## Timing
- Write: a word accepted at edge N is committed at edge N only if it completes a line; line_count and full update at that edge.
- Read latency: with write1_read0 first sampled 0 at edge N and line_count > 0, out_valid = 1 with word (0,0) after edge N+2. After that, one word per cycle while out_ready is held 1.
- overflow sets at the edge where the word is offered and stays set until reset or the next frame start.
- A mode change on the same edge as a line-completing write: the write commits first, then read start applies.

## Configuration
- LINE_RAM_PARITY_EN defined: each stored word carries one extra even-parity bit computed from data_in at write time. On read, parity is recomputed. parity_err = 1 for exactly the cycles in which out_valid = 1 and the presented word mismatches its stored parity.
- Not defined: storage is DATA_W bits per word, and parity_err is absent from the port list.

## Test plan
- Reset, then write 2×256 words with data_in = index (0..511), then read with out_ready = 1 -> line_count = 2, data_out sequence 0..511 (first valid at N+2), then empty = 1 and out_valid = 0.
- Write 300 words, then switch to read -> line_count = 1, exactly 256 words (0..255) out, and the 44-word partial line is never seen.
- Fill 32 lines (8192 words) then offer 0xBEEF -> full = 1, in_ready = 0, overflow = 1; readback of the last word returns 8191 & 0xFFFF.
- Read with out_ready toggled 1,0,0,1 -> data_out holds its value over the stalled cycles; no word is skipped or duplicated.
- Assert reset mid-read after word 100 -> out_valid = 0, data_out = 0, line_count = 0 and empty = 1 immediately.
- With LINE_RAM_PARITY_EN: force-flip bit 3 of stored word 5, then read -> parity_err = 1 only on word 5 and data_out = (5 ^ 0x0008).

Source files
------------

// File: rtl/line_buffer_ram_if.sv
// line_buffer_ram_if -- stream/status bundle for line_buffer_ram.
//   master: capture/consumer side (drives mode, write stream, out_ready)
//   slave : line_buffer_ram (drives in_ready, read stream, status flags)
// Optional: LINE_RAM_PARITY_EN adds parity_err to the bundle.
interface line_buffer_ram_if #(
  parameter int DATA_W = 16,
  parameter int LINES  = 32
);
  localparam int LA = $clog2(LINES);

  logic              write1_read0;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] data_out;
  logic [LA:0]       line_count;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef LINE_RAM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
`ifdef LINE_RAM_PARITY_EN
    input  parity_err,
`endif
    output write1_read0, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, line_count, full, empty, overflow
  );

  modport slave (
`ifdef LINE_RAM_PARITY_EN
    output parity_err,
`endif
    input  write1_read0, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, line_count, full, empty, overflow
  );
endinterface

// File: rtl/line_buffer_ram.sv
// line_buffer_ram -- line-oriented frame store.
// Write mode packs DATA_W words into lines of WORDS_PER_LINE and commits whole
// lines (up to LINES). Read mode replays committed lines in order through a
// valid/ready output register.
// Ports:
//   clock, reset : single clock, asynchronous active-high reset
//   bus (slave)  : write1_read0, in_valid/data_in/in_ready,
//                  out_valid/data_out/out_ready, line_count, full, empty,
//                  overflow (+ parity_err)
// Optional: define LINE_RAM_PARITY_EN to store an even-parity bit per word
// and flag mismatches on the presented word via parity_err.
module line_buffer_ram #(
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 256,
  parameter int LINES          = 32
) (
  input  logic             clock,
  input  logic             reset,
  line_buffer_ram_if.slave bus
);
  localparam int WA    = $clog2(WORDS_PER_LINE);
  localparam int LA    = $clog2(LINES);
  localparam int DEPTH = WORDS_PER_LINE * LINES;
`ifdef LINE_RAM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0] mem [DEPTH];

  logic              mode_q;       // registered mode, gates both sides
  logic [WA-1:0]     word_cnt;
  logic [LA-1:0]     wr_line;
  logic [LA:0]       line_count;
  logic              overflow_q;
  logic [WA-1:0]     rd_word;
  logic [LA:0]       rd_line;      // one extra bit so it can reach line_count
  logic [1:0]        vld_pipe;     // [0] fetch stage, [1] output register
  logic [MW-1:0]     rd_q;
  logic [DATA_W-1:0] data_q;
  logic [MW-1:0]     wdata;

  logic frame_start, read_start, full_w, wr_en;
  logic load_out, advance, fetch;

  assign frame_start = bus.write1_read0 & ~mode_q;
  assign read_start  = ~bus.write1_read0 & mode_q;
  assign full_w      = (line_count == (LA+1)'(LINES));
  assign wr_en       = mode_q & bus.in_valid & ~full_w;

  // Output register reloads when empty or drained; the fetch stage moves
  // whenever its word has somewhere to go.
  assign load_out = ~vld_pipe[1] | bus.out_ready;
  assign advance  = ~vld_pipe[0] | load_out;
  assign fetch    = advance & ~mode_q & ~bus.write1_read0 & (rd_line < line_count);

`ifdef LINE_RAM_PARITY_EN
  assign wdata = {^bus.data_in, bus.data_in};
`else
  assign wdata = bus.data_in;
`endif

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[{wr_line, word_cnt}] <= wdata;
    if (fetch) rd_q <= mem[{rd_line[LA-1:0], rd_word}];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q     <= 1'b0;
      word_cnt   <= '0;
      wr_line    <= '0;
      line_count <= '0;
      overflow_q <= 1'b0;
      rd_word    <= '0;
      rd_line    <= '0;
      vld_pipe   <= '0;
      data_q     <= '0;
    end else begin
      mode_q <= bus.write1_read0;

      if (frame_start) begin
        line_count <= '0;
        wr_line    <= '0;
        word_cnt   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (wr_en) begin
          word_cnt <= word_cnt + 1'b1;
          if (word_cnt == WA'(WORDS_PER_LINE - 1)) begin
            wr_line    <= wr_line + 1'b1;
            line_count <= line_count + 1'b1;
          end
        end
        if (mode_q & bus.in_valid & full_w) overflow_q <= 1'b1;
        // Line commit above lands first; only the partial tail is discarded.
        if (read_start) word_cnt <= '0;
      end

      // Anything outside steady read mode flushes the playback path.
      if (mode_q | bus.write1_read0) begin
        rd_word  <= '0;
        rd_line  <= '0;
        vld_pipe <= '0;
      end else begin
        if (fetch) begin
          rd_word <= rd_word + 1'b1;
          if (rd_word == WA'(WORDS_PER_LINE - 1)) rd_line <= rd_line + 1'b1;
        end
        if (advance) vld_pipe[0] <= fetch;
        if (load_out) begin
          vld_pipe[1] <= vld_pipe[0];
          if (vld_pipe[0]) data_q <= rd_q[DATA_W-1:0];
        end
      end
    end
  end

`ifdef LINE_RAM_PARITY_EN
  logic par_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    par_q <= 1'b0;
    else if (!(mode_q | bus.write1_read0) && load_out && vld_pipe[0])
                                                  par_q <= rd_q[DATA_W];
  end
  assign bus.parity_err = vld_pipe[1] & ((^data_q) != par_q);
`endif

  assign bus.in_ready   = mode_q & ~full_w;
  assign bus.out_valid  = vld_pipe[1];
  assign bus.data_out   = data_q;
  assign bus.line_count = line_count;
  assign bus.full       = full_w;
  assign bus.overflow   = overflow_q;
  assign bus.empty      = (line_count == '0) |
                          (~mode_q & (rd_line == line_count) & ~|vld_pipe);
endmodule
